// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer.
// State encoding, counter width helper and parity sense.
package sipo_pkg;

    typedef enum logic [0:0] {
        ST_SHIFT  = 1'b0,
        ST_PARITY = 1'b1
    } sipo_state_e;

    localparam logic EVEN_PARITY = 1'b0;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Bundle of the serial input side and the word output side.
// master: serial source / word consumer; slave: the deserializer.
// Ports: si, si_valid, frame_start, po, po_valid, po_ready,
// overrun, overrun_clr, bit_cnt (+ parity_err with SIPO_PARITY_EN).
interface sipo_deser_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic                       si;
    logic                       si_valid;
    logic                       frame_start;
    logic [WIDTH-1:0]           po;
    logic                       po_valid;
    logic                       po_ready;
    logic                       overrun;
    logic                       overrun_clr;
    logic [cnt_w(WIDTH)-1:0]    bit_cnt;
`ifdef SIPO_PARITY_EN
    logic                       parity_err;

    modport master (
        output si, si_valid, frame_start, po_ready, overrun_clr,
        input  po, po_valid, overrun, bit_cnt, parity_err
    );
    modport slave (
        input  si, si_valid, frame_start, po_ready, overrun_clr,
        output po, po_valid, overrun, bit_cnt, parity_err
    );
`else
    modport master (
        output si, si_valid, frame_start, po_ready, overrun_clr,
        input  po, po_valid, overrun, bit_cnt
    );
    modport slave (
        input  si, si_valid, frame_start, po_ready, overrun_clr,
        output po, po_valid, overrun, bit_cnt
    );
`endif
endinterface

// File: rtl/sipo_hold_reg.sv
// Valid/ready holding register with drop detection.
// Ports: clk, rst, load, word, ready in; po, po_valid, drop out.
module sipo_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             ready,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    output logic             drop
);

    // A new word is lost only if the old one is unread and not popped now.
    assign drop = load && po_valid && !ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            po       <= '0;
            po_valid <= 1'b0;
        end else if (load) begin
            if (!po_valid || ready) begin
                po       <= word;
                po_valid <= 1'b1;
            end
        end else if (po_valid && ready) begin
            po_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with framing, output
// handshake and sticky overrun. Ports: clk, rst, bus (slave).
// Optional macro SIPO_PARITY_EN adds an even-parity bit per frame
// and the parity_err output.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    sipo_deser_if.slave  bus
);

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_sh;
    logic [WIDTH-1:0] sr_fs;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             load;
    logic [WIDTH-1:0] word;
    logic             drop;
    logic             overrun;

    // sr_fs is an empty register with the coincident bit shifted in.
    always_comb begin
        sr_sh = sr;
        sr_fs = '0;
        if (MSB_FIRST) begin
            sr_sh = {sr[WIDTH-2:0], bus.si};
            sr_fs = {{(WIDTH-1){1'b0}}, bus.si};
        end else begin
            sr_sh = {bus.si, sr[WIDTH-1:1]};
            sr_fs = {bus.si, {(WIDTH-1){1'b0}}};
        end
    end

`ifdef SIPO_PARITY_EN
    sipo_state_e      state;
    logic             perr;
    logic [WIDTH:0]   hold_po;

    assign last = (state == ST_SHIFT) && bus.si_valid &&
                  !bus.frame_start && (cnt == LAST);
    assign load = (state == ST_PARITY) && bus.si_valid &&
                  !bus.frame_start;
    assign word = sr;
    assign perr = ((^sr) ^ bus.si) != EVEN_PARITY;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            cnt   <= '0;
            state <= ST_SHIFT;
        end else if (bus.frame_start) begin
            sr    <= bus.si_valid ? sr_fs : '0;
            cnt   <= bus.si_valid ? CW'(1) : '0;
            state <= ST_SHIFT;
        end else if (bus.si_valid) begin
            unique case (state)
                ST_SHIFT: begin
                    sr <= sr_sh;
                    if (last) begin
                        cnt   <= '0;
                        state <= ST_PARITY;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_PARITY: begin
                    state <= ST_SHIFT;
                end
                default: state <= ST_SHIFT;
            endcase
        end
    end

    sipo_hold_reg #(
        .WIDTH (WIDTH + 1)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .word     ({perr, word}),
        .ready    (bus.po_ready),
        .po       (hold_po),
        .po_valid (bus.po_valid),
        .drop     (drop)
    );

    assign bus.po         = hold_po[WIDTH-1:0];
    assign bus.parity_err = hold_po[WIDTH];
`else
    assign last = bus.si_valid && !bus.frame_start && (cnt == LAST);
    assign load = last;
    assign word = sr_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (bus.frame_start) begin
            sr  <= bus.si_valid ? sr_fs : '0;
            cnt <= bus.si_valid ? CW'(1) : '0;
        end else if (bus.si_valid) begin
            sr  <= sr_sh;
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

    sipo_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .word     (word),
        .ready    (bus.po_ready),
        .po       (bus.po),
        .po_valid (bus.po_valid),
        .drop     (drop)
    );
`endif

    // A drop and a clear on the same edge leave the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (bus.overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    assign bus.overrun = overrun;
    assign bus.bit_cnt = cnt;

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus
// and are compared against a bit-queue frame model.
module tb_sipo_deser;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sipo_deser_if #(.WIDTH(8)) bm ();
    sipo_deser_if #(.WIDTH(8)) bl ();

    assign bl.si          = bm.si;
    assign bl.si_valid    = bm.si_valid;
    assign bl.frame_start = bm.frame_start;
    assign bl.po_ready    = bm.po_ready;
    assign bl.overrun_clr = bm.overrun_clr;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bm.slave)
    );

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bl.slave)
    );

`ifdef SIPO_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    int checks = 0;
    int errors = 0;

    bit         mq[$];
    logic [7:0] m_po_m;
    logic [7:0] m_po_l;
    logic       m_valid;
    logic       m_ovr;
    logic       m_perr;

    function automatic logic [2:0] m_cnt();
        return 3'(mq.size() % 8);
    endfunction

    task automatic step(input bit r, input bit s, input bit v,
                        input bit fs, input bit rdy, input bit clr);
        bit         done;
        bit         drop;
        logic [7:0] wm;
        logic [7:0] wl;
        bit         px;
        rst            = r;
        bm.si          = s;
        bm.si_valid    = v;
        bm.frame_start = fs;
        bm.po_ready    = rdy;
        bm.overrun_clr = clr;
        @(posedge clk);
        done = 0;
        drop = 0;
        wm   = '0;
        wl   = '0;
        px   = 0;
        if (r) begin
            mq.delete();
            m_po_m  = '0;
            m_po_l  = '0;
            m_valid = 0;
            m_ovr   = 0;
            m_perr  = 0;
        end else begin
            if (fs) begin
                mq.delete();
                if (v) mq.push_back(s);
            end else if (v) begin
                mq.push_back(s);
                if (mq.size() == FRAME) begin
                    done = 1;
                    for (int i = 0; i < 8; i++) begin
                        wm[7-i] = mq[i];
                        wl[i]   = mq[i];
                    end
                    for (int i = 0; i < FRAME; i++) px ^= mq[i];
                    mq.delete();
                end
            end
            if (done) begin
                if (!m_valid || rdy) begin
                    m_po_m  = wm;
                    m_po_l  = wl;
                    m_perr  = px;
                    m_valid = 1;
                end else begin
                    drop = 1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
            if (drop) m_ovr = 1;
            else if (clr) m_ovr = 0;
        end
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, rdy, 0);
    endtask

    task automatic send_word(input logic [7:0] w, input bit rdy,
                             input bit rdy_last, input bit par);
        for (int i = 0; i < 8; i++) begin
            step(0, w[7-i], 1, 0,
                 (i == 7 && FRAME == 8) ? rdy_last : rdy, 0);
        end
        if (FRAME == 9) step(0, par, 1, 0, rdy_last, 0);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1, 0);
        checks++;
        if (bm.po !== 8'h00 || bm.po_valid !== 1'b0 ||
            bm.overrun !== 1'b0 || bm.bit_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset got po=%h v=%b o=%b c=%0d want 00 0 0 0",
                     bm.po, bm.po_valid, bm.overrun, bm.bit_cnt);
        end
        checks++;
        if (bl.po !== 8'h00 || bl.po_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_lsb got po=%h v=%b want 00 0",
                     bl.po, bl.po_valid);
        end
    endtask

    task automatic test_word_a5();
        send_word(8'hA5, 1, 1, 0);
        checks++;
        if (bm.po !== 8'hA5 || bm.po_valid !== 1'b1 ||
            bm.bit_cnt !== 3'd0) begin
            errors++;
            $display("FAIL a5 got po=%h v=%b c=%0d want a5 1 0",
                     bm.po, bm.po_valid, bm.bit_cnt);
        end
        idle(1);
        checks++;
        if (bm.po_valid !== 1'b0 || bm.po !== 8'hA5) begin
            errors++;
            $display("FAIL a5_pulse got v=%b po=%h want 0 a5",
                     bm.po_valid, bm.po);
        end
    endtask

    task automatic test_bit_order();
        send_word(8'hC0, 1, 1, 0);
        checks++;
        if (bm.po !== 8'hC0 || bl.po !== 8'h03) begin
            errors++;
            $display("FAIL bit_order got msb=%h lsb=%h want c0 03",
                     bm.po, bl.po);
        end
        idle(1);
    endtask

    task automatic test_frame_start();
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 0);
        step(0, 1, 1, 1, 1, 0);
        checks++;
        if (bm.bit_cnt !== 3'd1) begin
            errors++;
            $display("FAIL fs_cnt got %0d want 1", bm.bit_cnt);
        end
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 1, 0);
        if (FRAME == 9) step(0, 1, 1, 0, 1, 0);
        checks++;
        if (bm.po !== 8'h80 || bl.po !== 8'h01 ||
            bm.po_valid !== 1'b1) begin
            errors++;
            $display("FAIL frame_start got msb=%h lsb=%h v=%b want 80 01 1",
                     bm.po, bl.po, bm.po_valid);
        end
        idle(1);
    endtask

    task automatic test_overrun();
        send_word(8'h11, 0, 0, 0);
        checks++;
        if (bm.po !== 8'h11 || bm.po_valid !== 1'b1 ||
            bm.overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first got po=%h v=%b o=%b want 11 1 0",
                     bm.po, bm.po_valid, bm.overrun);
        end
        send_word(8'h22, 0, 0, 0);
        checks++;
        if (bm.po !== 8'h11 || bm.overrun !== 1'b1 ||
            bl.po !== m_po_l) begin
            errors++;
            $display("FAIL ovr_drop got po=%h o=%b lsb=%h want 11 1 %h",
                     bm.po, bm.overrun, bl.po, m_po_l);
        end
        idle(1);
        checks++;
        if (bm.po_valid !== 1'b0 || bm.overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_pop got v=%b o=%b want 0 1",
                     bm.po_valid, bm.overrun);
        end
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (bm.overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clr got %b want 0", bm.overrun);
        end
    endtask

    task automatic test_back_to_back();
        send_word(8'h33, 0, 0, 0);
        send_word(8'h44, 0, 1, 1);
        checks++;
        if (bm.po !== 8'h44 || bm.po_valid !== 1'b1 ||
            bm.overrun !== 1'b0 || bl.po !== m_po_l) begin
            errors++;
            $display("FAIL b2b got po=%h v=%b o=%b lsb=%h want 44 1 0 %h",
                     bm.po, bm.po_valid, bm.overrun, bl.po, m_po_l);
        end
        idle(1);
    endtask

    task automatic test_reset_mid_word();
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 1, 0);
        checks++;
        if (bm.bit_cnt !== 3'd0 || bm.po !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid got c=%0d po=%h want 0 00",
                     bm.bit_cnt, bm.po);
        end
        send_word(8'h5A, 1, 1, 0);
        checks++;
        if (bm.po !== 8'h5A || bm.po_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_word got po=%h v=%b want 5a 1",
                     bm.po, bm.po_valid);
        end
`ifdef SIPO_PARITY_EN
        checks++;
        if (bm.parity_err !== 1'b0) begin
            errors++;
            $display("FAIL par_ok got %b want 0", bm.parity_err);
        end
        idle(1);
        send_word(8'h5A, 1, 1, 1);
        checks++;
        if (bm.parity_err !== 1'b1) begin
            errors++;
            $display("FAIL par_bad got %b want 1", bm.parity_err);
        end
`endif
        idle(1);
    endtask

    task automatic test_random();
        bit r, s, v, fs, rdy, clr;
        for (int n = 0; n < 1500; n++) begin
            r   = ($urandom % 400) == 0;
            s   = $urandom % 2;
            v   = ($urandom % 4) != 0;
            fs  = ($urandom % 40) == 0;
            rdy = ($urandom % 3) != 0;
            clr = ($urandom % 16) == 0;
            step(r, s, v, fs, rdy, clr);
            checks++;
            if (bm.po !== m_po_m || bl.po !== m_po_l ||
                bm.po_valid !== m_valid || bl.po_valid !== m_valid ||
                bm.overrun !== m_ovr || bl.overrun !== m_ovr ||
                bm.bit_cnt !== m_cnt() || bl.bit_cnt !== m_cnt()) begin
                errors++;
                $display("FAIL rand[%0d] got %h %h %b %b %0d want %h %h %b %b %0d",
                         n, bm.po, bl.po, bm.po_valid, bm.overrun,
                         bm.bit_cnt, m_po_m, m_po_l, m_valid, m_ovr,
                         m_cnt());
            end
`ifdef SIPO_PARITY_EN
            checks++;
            if (bm.parity_err !== m_perr || bl.parity_err !== m_perr) begin
                errors++;
                $display("FAIL rand_par[%0d] got %b want %b",
                         n, bm.parity_err, m_perr);
            end
`endif
        end
    endtask

    initial begin
        bm.si          = 1'b0;
        bm.si_valid    = 1'b0;
        bm.frame_start = 1'b0;
        bm.po_ready    = 1'b0;
        bm.overrun_clr = 1'b0;
        test_reset();
        test_word_a5();
        test_bit_order();
        test_frame_start();
        test_overrun();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
